// File: rtl/modmul_arbiter.sv
// modmul_arbiter: round-robin arbiter and sequencer sharing one modular
// multiplier core among NREQ requesters, with a watchdog for a hung core.
module modmul_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 256,
  parameter int TIMEOUT = 1023,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_q,
  output logic              rsp_err,
  output logic              mm_start,
  output logic [W-1:0]      mm_x,
  output logic [W-1:0]      mm_y,
  output logic              mm_rst,
  input  logic              mm_done,
  input  logic [W-1:0]      mm_q,
  output logic              busy,
  output logic [IDW-1:0]    active_id
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ISSUE, S_WAIT, S_CLR1, S_CLR2, S_RESP
  } state_t;

  // Watchdog counter only needs to reach TIMEOUT-1; a zero TIMEOUT disables it.
  localparam int             WCW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit             WD_EN = (TIMEOUT != 0);
  localparam logic [WCW-1:0] WLAST = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [NREQ-1:0] ONE  = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  grant;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  ptr_nxt;
  logic [WCW-1:0]  wcnt;
  logic            init_cnt;
  logic            any_req;
  logic            accept;
  logic            timed_out;
  logic [W-1:0]    x_sel;
  logic [W-1:0]    y_sel;

  // Round-robin search starting at ptr; scanning downward lets the lowest
  // offset from ptr win, and the chosen operands are muxed out by grant.
  always_comb begin
    grant   = '0;
    cand    = '0;
    x_sel   = '0;
    y_sel   = '0;
    any_req = |req_valid;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (req_valid[cand]) grant = cand;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        x_sel = req_x[i*W +: W];
        y_sel = req_y[i*W +: W];
      end
    end
    ptr_nxt   = IDW'((int'(grant) + 1) % NREQ);
    timed_out = WD_EN && (wcnt == WLAST);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  // Next-state logic and the state-decoded control outputs.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    mm_start  = 1'b0;
    mm_rst    = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    case (state)
      S_INIT: begin
        mm_rst = 1'b1;
        if (init_cnt) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        busy = 1'b0;
        if (any_req) begin
          req_ready = ONE << grant;
          accept    = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mm_start  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mm_done || timed_out) state_nxt = S_CLR1;
      end
      S_CLR1: begin
        mm_rst    = 1'b1;
        state_nxt = S_CLR2;
      end
      S_CLR2: begin
        mm_rst    = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = ONE << active_id;
        if (rsp_ready[active_id]) state_nxt = S_IDLE;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // Datapath: operand capture on accept, watchdog count, result capture.
  // A real done beats a simultaneous watchdog expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      wcnt      <= '0;
      init_cnt  <= 1'b0;
      mm_x      <= '0;
      mm_y      <= '0;
      active_id <= '0;
      rsp_q     <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == S_INIT) init_cnt <= 1'b1;
      if (accept) begin
        mm_x      <= x_sel;
        mm_y      <= y_sel;
        active_id <= grant;
        ptr       <= ptr_nxt;
      end
      if (state == S_ISSUE) wcnt <= '0;
      if (state == S_WAIT) begin
        if (mm_done) begin
          rsp_q   <= mm_q;
          rsp_err <= 1'b0;
        end else if (timed_out) begin
          rsp_q   <= '0;
          rsp_err <= 1'b1;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_modmul_arbiter.sv
// Directed bench for modmul_arbiter: a 4-requester instance with a behavioural
// core, and a 2-requester instance with TIMEOUT=16 whose core is hand-driven.
module tb_modmul_arbiter;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1023:0]  req_x, req_y;
  logic [255:0]   rsp_q, mm_x, mm_y, core_q;
  logic           rsp_err, mm_start, mm_rst, core_done, busy;
  logic [1:0]     active_id;

  logic [1:0]     w_req_valid, w_req_ready, w_rsp_valid, w_rsp_ready;
  logic [511:0]   w_req_x, w_req_y;
  logic [255:0]   w_rsp_q, w_mm_x, w_mm_y, w_q;
  logic           w_rsp_err, w_mm_start, w_mm_rst, w_done, w_busy;
  logic [0:0]     w_active_id;

  int checks = 0;
  int errors = 0;
  int core_delay = 3;
  int core_cnt = 0;
  logic core_busy = 1'b0;

  modmul_arbiter #(.NREQ(4), .W(256), .TIMEOUT(1023), .IDW(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_err(rsp_err),
    .mm_start(mm_start), .mm_x(mm_x), .mm_y(mm_y), .mm_rst(mm_rst),
    .mm_done(core_done), .mm_q(core_q), .busy(busy), .active_id(active_id)
  );

  modmul_arbiter #(.NREQ(2), .W(256), .TIMEOUT(16), .IDW(1)) u_wd (
    .clk(clk), .rst(rst),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_x(w_req_x), .req_y(w_req_y),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_q(w_rsp_q), .rsp_err(w_rsp_err),
    .mm_start(w_mm_start), .mm_x(w_mm_x), .mm_y(w_mm_y), .mm_rst(w_mm_rst),
    .mm_done(w_done), .mm_q(w_q), .busy(w_busy), .active_id(w_active_id)
  );

  always #5 clk = ~clk;

  // Core model: done rises core_delay cycles after the start pulse, sticks until mm_rst.
  always @(negedge clk) begin
    if (mm_rst) begin
      core_done = 1'b0;
      core_busy = 1'b0;
    end else if (mm_start) begin
      core_busy = 1'b1;
      core_cnt  = core_delay;
      core_q    = mm_x * mm_y;
    end else if (core_busy) begin
      core_cnt = core_cnt - 1;
      if (core_cnt == 0) begin
        core_done = 1'b1;
        core_busy = 1'b0;
      end
    end
  end

  task automatic set_op(input int i, input logic [255:0] x, input logic [255:0] y);
    req_x[i*256 +: 256] = x;
    req_y[i*256 +: 256] = y;
  endtask

  task automatic wait_rsp(input int bound, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid != 4'b0000) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if (rsp_q !== 256'd0 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp: got q=%0h err=%b expected 0/0", rsp_q, rsp_err); end
    checks++; if (mm_x !== 256'd0 || mm_y !== 256'd0) begin errors++; $display("[TB] FAIL reset_operands: got %0h/%0h expected 0/0", mm_x, mm_y); end
    checks++; if (mm_start !== 1'b0 || active_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_start_id: got %b/%0d expected 0/0", mm_start, active_id); end
    checks++; if (mm_rst !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_mmrst_busy: got %b/%b expected 1/1", mm_rst, busy); end
    checks++; if (w_mm_rst !== 1'b1 || w_busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_wd_mmrst_busy: got %b/%b expected 1/1", w_mm_rst, w_busy); end
    req_valid = 4'b0000;
    rst = 1'b0;
    #1;
    n = 0;
    if (mm_rst) n++;
    repeat (5) begin
      @(negedge clk);
      if (mm_rst) n++;
    end
    checks++; if (n != 2) begin errors++; $display("[TB] FAIL init_mmrst_cycles: got %0d expected 2", n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL init_to_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin;
    int cyc;
    bit ok;
    int exp_id;
    logic [3:0] exp_v;
    logic [255:0] exp_q;
    core_delay = 3;
    for (int i = 0; i < 4; i++) set_op(i, 256'(i + 2), 256'(10 + i));
    rsp_ready = 4'b1111;
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      exp_id = j % 4;
      exp_v  = 4'(1 << exp_id);
      exp_q  = 256'((exp_id + 2) * (10 + exp_id));
      wait_rsp(100, cyc, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL rr_rsp_timeout: got no response expected job %0d", j); end
      checks++; if (rsp_valid !== exp_v) begin errors++; $display("[TB] FAIL rr_grant: got %b expected %b", rsp_valid, exp_v); end
      checks++; if (rsp_q !== exp_q) begin errors++; $display("[TB] FAIL rr_product: got %0d expected %0d", rsp_q, exp_q); end
      checks++; if (active_id !== 2'(exp_id)) begin errors++; $display("[TB] FAIL rr_active_id: got %0d expected %0d", active_id, exp_id); end
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_single_job;
    int cyc, starts, rsts, start_cyc;
    bit ok;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: got busy=%b expected 0", busy); end
    core_delay = 40;
    set_op(1, 256'd3, 256'd5);
    rsp_ready = 4'b0010;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL single_req_ready: got %b expected 0010", req_ready); end
    starts = 0; rsts = 0; start_cyc = 0; cyc = 0; ok = 1'b0;
    while (!ok && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mm_start) begin
        starts++;
        start_cyc = cyc;
        req_valid = 4'b0000;
        checks++; if (mm_x !== 256'd3 || mm_y !== 256'd5 || active_id !== 2'd1) begin errors++; $display("[TB] FAIL single_issue: got x=%0d y=%0d id=%0d expected 3/5/1", mm_x, mm_y, active_id); end
      end
      if (mm_rst) rsts++;
      if (rsp_valid != 4'b0000) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL single_rsp_timeout: got no response expected one"); end
    checks++; if (starts != 1) begin errors++; $display("[TB] FAIL single_start_pulses: got %0d expected 1", starts); end
    checks++; if (rsts != 2) begin errors++; $display("[TB] FAIL single_mmrst_cycles: got %0d expected 2", rsts); end
    checks++; if (cyc - start_cyc != 43) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 43", cyc - start_cyc); end
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("[TB] FAIL single_rsp_valid: got %b expected 0010", rsp_valid); end
    checks++; if (rsp_q !== 256'd15 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL single_rsp_q: got q=%0d err=%b expected 15/0", rsp_q, rsp_err); end
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_handshake: got valid=%b busy=%b expected 0000/0", rsp_valid, busy); end
  endtask

  task automatic test_backpressure;
    int cyc, bad;
    bit ok;
    core_delay = 4;
    set_op(2, 256'd6, 256'd7);
    set_op(0, 256'd7, 256'd9);
    rsp_ready = 4'b1011;
    req_valid = 4'b0101;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL bp_grant_from_ptr: got %b expected 0100", req_ready); end
    wait_rsp(100, cyc, ok);
    checks++; if (!ok || rsp_valid !== 4'b0100 || rsp_q !== 256'd42) begin errors++; $display("[TB] FAIL bp_first_rsp: got valid=%b q=%0d expected 0100/42", rsp_valid, rsp_q); end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0100 || rsp_q !== 256'd42 || rsp_err !== 1'b0 || req_ready !== 4'b0000 || mm_start !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL bp_hold_stable: got %0d unstable cycles expected 0", bad); end
    rsp_ready = 4'b0100;
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0 || req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL bp_after_handshake: got valid=%b busy=%b ready=%b expected 0000/0/0001", rsp_valid, busy, req_ready); end
    @(negedge clk);
    checks++; if (mm_start !== 1'b1 || active_id !== 2'd0 || mm_x !== 256'd7) begin errors++; $display("[TB] FAIL bp_next_accept: got start=%b id=%0d x=%0d expected 1/0/7", mm_start, active_id, mm_x); end
    req_valid = 4'b0000;
    rsp_ready = 4'b0001;
    wait_rsp(100, cyc, ok);
    checks++; if (!ok || rsp_valid !== 4'b0001 || rsp_q !== 256'd63) begin errors++; $display("[TB] FAIL bp_second_rsp: got valid=%b q=%0d expected 0001/63", rsp_valid, rsp_q); end
  endtask

  task automatic test_withdraw;
    int cyc;
    bit ok, saw3;
    @(negedge clk);
    core_delay = 8;
    set_op(1, 256'd11, 256'd3);
    req_valid = 4'b0010;
    rsp_ready = 4'b0010;
    @(negedge clk);
    req_valid = 4'b1000;
    saw3 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (req_ready[3]) saw3 = 1'b1;
    end
    req_valid = 4'b0000;
    wait_rsp(100, cyc, ok);
    checks++; if (!ok || rsp_valid !== 4'b0010 || rsp_q !== 256'd33) begin errors++; $display("[TB] FAIL wd_inservice_rsp: got valid=%b q=%0d expected 0010/33", rsp_valid, rsp_q); end
    req_valid = 4'b0001;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL withdraw_not_granted: got %b expected 0001", req_ready); end
    rsp_ready = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    checks++; if (active_id !== 2'd0) begin errors++; $display("[TB] FAIL withdraw_active_id: got %0d expected 0", active_id); end
    wait_rsp(100, cyc, ok);
    checks++; if (!ok || rsp_valid !== 4'b0001 || saw3) begin errors++; $display("[TB] FAIL withdraw_rsp: got valid=%b saw3=%b expected 0001/0", rsp_valid, saw3); end
  endtask

  task automatic test_reset_mid_wait;
    int cyc, n_rst, n_rv;
    bit ok;
    @(negedge clk);
    core_delay = 40;
    set_op(2, 256'd9, 256'd9);
    req_valid = 4'b0100;
    rsp_ready = 4'b0100;
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 4'b0000 || rsp_q !== 256'd0 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rsp: got valid=%b q=%0d err=%b expected 0000/0/0", rsp_valid, rsp_q, rsp_err); end
    checks++; if (mm_x !== 256'd0 || mm_y !== 256'd0 || active_id !== 2'd0) begin errors++; $display("[TB] FAIL midrst_regs: got x=%0d y=%0d id=%0d expected 0/0/0", mm_x, mm_y, active_id); end
    checks++; if (mm_rst !== 1'b1 || busy !== 1'b1 || mm_start !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ctrl: got rst=%b busy=%b start=%b expected 1/1/0", mm_rst, busy, mm_start); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_rst = 0; n_rv = 0;
    if (mm_rst) n_rst++;
    repeat (60) begin
      @(negedge clk);
      if (mm_rst) n_rst++;
      if (rsp_valid != 4'b0000) n_rv++;
    end
    checks++; if (n_rst != 2) begin errors++; $display("[TB] FAIL midrst_init_cycles: got %0d expected 2", n_rst); end
    checks++; if (n_rv != 0) begin errors++; $display("[TB] FAIL midrst_no_rsp: got %0d valid cycles expected 0", n_rv); end
    set_op(3, 256'd5, 256'd5);
    req_valid = 4'b1000;
    rsp_ready = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL midrst_next_ready: got %b expected 1000", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    wait_rsp(100, cyc, ok);
    checks++; if (!ok || rsp_valid !== 4'b1000 || rsp_q !== 256'd25 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_next_rsp: got valid=%b q=%0d err=%b expected 1000/25/0", rsp_valid, rsp_q, rsp_err); end
  endtask

  task automatic test_done_and_timeout;
    @(negedge clk);
    w_req_x[255:0] = 256'd17;
    w_req_y[255:0] = 256'd2;
    w_rsp_ready = 2'b01;
    w_req_valid = 2'b01;
    #1;
    checks++; if (w_req_ready !== 2'b01) begin errors++; $display("[TB] FAIL tie_req_ready: got %b expected 01", w_req_ready); end
    @(negedge clk);
    w_req_valid = 2'b00;
    checks++; if (w_mm_start !== 1'b1) begin errors++; $display("[TB] FAIL tie_start: got %b expected 1", w_mm_start); end
    repeat (16) @(negedge clk);
    checks++; if (w_mm_rst !== 1'b0 || w_busy !== 1'b1) begin errors++; $display("[TB] FAIL tie_still_wait: got rst=%b busy=%b expected 0/1", w_mm_rst, w_busy); end
    w_done = 1'b1;
    w_q = 256'd123;
    @(negedge clk);
    w_done = 1'b0;
    checks++; if (w_mm_rst !== 1'b1 || w_rsp_err !== 1'b0 || w_rsp_q !== 256'd123) begin errors++; $display("[TB] FAIL tie_done_wins: got rst=%b err=%b q=%0d expected 1/0/123", w_mm_rst, w_rsp_err, w_rsp_q); end
    repeat (2) @(negedge clk);
    checks++; if (w_rsp_valid !== 2'b01 || w_rsp_q !== 256'd123) begin errors++; $display("[TB] FAIL tie_rsp: got valid=%b q=%0d expected 01/123", w_rsp_valid, w_rsp_q); end
  endtask

  task automatic test_timeout;
    int bad;
    @(negedge clk);
    w_req_valid = 2'b01;
    @(negedge clk);
    w_req_valid = 2'b00;
    bad = 0;
    repeat (16) begin
      @(negedge clk);
      if (w_mm_rst || w_rsp_err || !w_busy) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL to_early_expiry: got %0d bad cycles expected 0", bad); end
    @(negedge clk);
    checks++; if (w_rsp_err !== 1'b1 || w_rsp_q !== 256'd0 || w_mm_rst !== 1'b1) begin errors++; $display("[TB] FAIL to_expiry: got err=%b q=%0d rst=%b expected 1/0/1", w_rsp_err, w_rsp_q, w_mm_rst); end
    @(negedge clk);
    checks++; if (w_mm_rst !== 1'b1) begin errors++; $display("[TB] FAIL to_clr2: got %b expected 1", w_mm_rst); end
    @(negedge clk);
    checks++; if (w_rsp_valid !== 2'b01 || w_rsp_err !== 1'b1 || w_rsp_q !== 256'd0) begin errors++; $display("[TB] FAIL to_rsp: got valid=%b err=%b q=%0d expected 01/1/0", w_rsp_valid, w_rsp_err, w_rsp_q); end
    @(negedge clk);
    checks++; if (w_busy !== 1'b0 || w_mm_rst !== 1'b0) begin errors++; $display("[TB] FAIL to_idle: got busy=%b rst=%b expected 0/0", w_busy, w_mm_rst); end
    w_req_valid = 2'b01;
    @(negedge clk);
    w_req_valid = 2'b00;
    repeat (5) @(negedge clk);
    w_done = 1'b1;
    w_q = 256'd200;
    @(negedge clk);
    w_done = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (w_rsp_valid !== 2'b01 || w_rsp_q !== 256'd200 || w_rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL to_recover: got valid=%b q=%0d err=%b expected 01/200/0", w_rsp_valid, w_rsp_q, w_rsp_err); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_time_limit: got no finish expected finish before 100000 ns");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; rsp_ready = '0; req_x = '0; req_y = '0;
    w_req_valid = '0; w_rsp_ready = '0; w_req_x = '0; w_req_y = '0;
    w_done = 1'b0; w_q = '0;
    core_done = 1'b0; core_q = '0;
    test_reset;
    test_round_robin;
    test_single_job;
    test_backpressure;
    test_withdraw;
    test_reset_mid_wait;
    test_done_and_timeout;
    test_timeout;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/modmul_arbiter.md
Name: modmul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 256-bit modular multiplier core among NREQ requesters.
- The core has a start/done interface, and its done flag stays high until the core's reset is asserted.
- Accepts operand pairs and issues one start pulse per job.
- Captures the result, clears the core by pulsing its reset, and returns the result to the granted requester over a valid/ready response channel. A watchdog recovers from a hung core.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 256, operand/result width
TIMEOUT, 1023, max WAIT cycles before error; 0 disables the watchdog
IDW, 2, requester ID width, equal to clog2(NREQ)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester job request
req_ready  out  NREQ  one-hot accept, combinational
req_x  in  NREQ*W  operand X of requester i at [i*W +: W]
req_y  in  NREQ*W  operand Y of requester i at [i*W +: W]
rsp_valid  out  NREQ  one-hot response valid
rsp_ready  in  NREQ  per-requester response accept
rsp_q  out  W  result of the current response
rsp_err  out  1  1 = response produced by timeout; rsp_q=0
mm_start  out  1  core start pulse
mm_x  out  W  core operand X (registered)
mm_y  out  W  core operand Y (registered)
mm_rst  out  1  core reset; clears sticky done
mm_done  in  1  core done (sticky)
mm_q  in  W  core result, valid while mm_done=1
busy  out  1  high in every state except IDLE
active_id  out  IDW  ID of the granted requester

Behaviour:
- Reset state: INIT, ptr=0, wcnt=0, init counter=0. Outputs: rsp_valid=0, rsp_q=0, rsp_err=0, mm_start=0, mm_x=mm_y=0, active_id=0. mm_rst=1 and busy=1 while in INIT.
- States: INIT, IDLE, ISSUE, WAIT, CLR1, CLR2, RESP.
- INIT: mm_rst=1 for 2 cycles after reset deasserts, then go to IDLE.
- IDLE arbitration:
  - grant = first i with req_valid[i], scanning ptr, ptr+1, ..., wrapping mod NREQ.
  - req_ready = onehot(grant) only in IDLE when any req_valid is high; 0 otherwise.
  - On accept: latch req_x/req_y slice into mm_x/mm_y, set active_id=grant, ptr <= (grant+1) mod NREQ, go to ISSUE.
- ISSUE: mm_start=1 for exactly one cycle; wcnt <= 0; go to WAIT.
- WAIT:
  - If mm_done=1: rsp_q <= mm_q, rsp_err <= 0, go to CLR1.
  - Else if TIMEOUT!=0 and wcnt==TIMEOUT-1: rsp_q <= 0, rsp_err <= 1, go to CLR1.
  - Else wcnt++.
  - mm_done and timeout in the same cycle: mm_done wins.
- CLR1, CLR2: mm_rst=1; then go to RESP.
- RESP:
  - rsp_valid[active_id]=1; rsp_q and rsp_err held stable.
  - When rsp_ready[active_id]=1 (including the first RESP cycle), drop rsp_valid next cycle and go to IDLE.
  - rsp_ready of other requesters is ignored.
- Latency: accept at cycle A; mm_start at A+1; mm_done first seen at D; rsp_valid from D+3. Minimum 2 cycles from a RESP handshake to the next accept (RESP→IDLE→accept).
- mm_start is never asserted outside ISSUE. mm_rst is never asserted outside INIT/CLR1/CLR2.
- Requester protocol: hold req_valid and operands stable until req_ready. Dropping req_valid before grant withdraws the request silently. Only one outstanding job per arbiter.
- Fairness: a continuously requesting requester waits at most NREQ-1 jobs.
- mm_done seen high in IDLE/ISSUE (stale) is ignored; CLR states guarantee it is cleared before the next job.
- Reset mid-operation: immediate return to the reset state; the in-flight job is discarded and no response is issued.

Test Plan:
- Single job: req_valid=4'b0010, X=3, Y=5; core model asserts mm_done 40 cycles after start with mm_q=15 → req_ready=4'b0010 in 1 cycle, one mm_start pulse, rsp_valid=4'b0010, rsp_q=15, rsp_err=0, mm_rst high exactly 2 cycles.
- Round-robin: req_valid=4'b1111 held, rsp_ready tied 1 → grant order 0,1,2,3,0; ptr wraps; each response carries the correct requester's product.
- Timeout: TIMEOUT=16, core never asserts mm_done → rsp_err=1 and rsp_q=0 exactly 16 WAIT cycles after entering WAIT, followed by 2 mm_rst cycles; the next job then completes normally.
- Response backpressure: rsp_ready low for 10 cycles → rsp_valid, rsp_q, rsp_err stable; no new req_ready during that time; accept occurs 2 cycles after the handshake.
- Boundary: mm_done and timeout in the same cycle → rsp_err=0, rsp_q=mm_q. Request withdrawn (req_valid dropped) while another requester is in service → it is never granted.
- Async reset asserted mid-WAIT → outputs go to reset values immediately; no rsp_valid pulse; mm_rst high 2 cycles after release; then normal operation.
